// File: rtl/slc3_step_driver.sv
// Run/Continue button sequencer for the SLC-3: loads S, presses Run once, then
// issues N Continue press/release pairs (or free-runs) at a programmable half-period.
module slc3_step_driver #(
   parameter int CNT_W  = 16,
   parameter int HALF_W = 8,
   parameter int SW_W   = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Abort,
   input  logic [CNT_W-1:0]  Steps,
   input  logic [HALF_W-1:0] Half,
   input  logic [SW_W-1:0]   S_in,
   output logic              Run,
   output logic              Continue,
   output logic [SW_W-1:0]   S,
   output logic              Busy,
   output logic              Done,
   output logic [CNT_W-1:0]  Step_cnt
);

   typedef enum logic [2:0] {
      IDLE, RUN_PRESS, RUN_REL, CONT_PRESS, CONT_REL, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [HALF_W-1:0] hcnt_q, hcnt_d;
   logic [HALF_W-1:0] h_q, h_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [SW_W-1:0]   s_q, s_d;
   logic [CNT_W-1:0]  step_q, step_d;
   logic              run_q, cont_q, busy_q, done_q;
   logic              last;
   logic              free_run;

   assign last     = (hcnt_q == '0);
   assign free_run = &n_q;

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      n_d     = n_q;
      s_d     = s_q;
      step_d  = step_q;
      hcnt_d  = hcnt_q - HALF_W'(1);
      case (state_q)
         IDLE: begin
            hcnt_d = hcnt_q;
            if (Start && !Abort) begin
               state_d = RUN_PRESS;
               h_d     = (Half == '0) ? HALF_W'(1) : Half;
               n_d     = Steps;
               s_d     = S_in;
               step_d  = '0;
            end
         end
         RUN_PRESS:  if (last) state_d = RUN_REL;
         RUN_REL:    if (last) state_d = (n_q == '0) ? DONE : CONT_PRESS;
         CONT_PRESS: if (last) state_d = CONT_REL;
         CONT_REL: begin
            if (last) begin
               step_d  = step_q + CNT_W'(1);
               state_d = (!free_run && step_d == n_q) ? DONE : CONT_PRESS;
            end
         end
         DONE: begin
            hcnt_d  = hcnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort drops the sequence but leaves S and the pulse count for inspection
      if (Abort && state_q != IDLE) begin
         state_d = IDLE;
         step_d  = step_q;
      end
      if (state_d != state_q) hcnt_d = h_d - HALF_W'(1);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         hcnt_q  <= '0;
         h_q     <= '0;
         n_q     <= '0;
         s_q     <= '0;
         step_q  <= '0;
         run_q   <= 1'b1;
         cont_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         h_q     <= h_d;
         n_q     <= n_d;
         s_q     <= s_d;
         step_q  <= step_d;
         // outputs decoded from the next state so they are registered yet aligned with it
         run_q   <= (state_d != RUN_PRESS);
         cont_q  <= (state_d != CONT_PRESS);
         busy_q  <= (state_d != IDLE) && (state_d != DONE);
         done_q  <= (state_d == DONE);
      end
   end

   assign Run      = run_q;
   assign Continue = cont_q;
   assign S        = s_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Step_cnt = step_q;

endmodule

// File: doc/slc3_step_driver.md
# slc3_step_driver

Synthesizable Run/Continue sequencer for the SLC-3 top level. It replaces hand-written press/release stimulus and manual button stepping with a programmable engine. After a start request it loads a switch value, presses Run once, then issues a configurable number of Continue press/release pairs at a programmable half-period. Its active-low outputs drive the SLC-3 Run, Continue and S inputs directly, either in the bench or on the board in place of the push-buttons.

## Interface
- CNT_W, 16, width of step count and step counter
- HALF_W, 8, width of half-period field (cycles per press or release level)
- SW_W, 16, width of switch value driven to S
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high
- Start  in  1  level; sampled only in IDLE; begins a sequence
- Abort  in  1  level; releases all buttons and returns to IDLE
- Steps  in  CNT_W  number of Continue pulses; all-ones selects free-run mode
- Half  in  HALF_W  cycles per press level and per release level; 0 is treated as 1
- S_in  in  SW_W  switch value to present during the sequence
- Run  out  1  active-low Run button
- Continue  out  1  active-low Continue button
- S  out  SW_W  registered switch value
- Busy  out  1  high while a sequence is in progress
- Done  out  1  one-cycle pulse when a sequence completes normally
- Step_cnt  out  CNT_W  Continue pulses completed in the current or last sequence

## Operation
- States: IDLE, RUN_PRESS, RUN_REL, CONT_PRESS, CONT_REL, DONE.
- IDLE: Run=1, Continue=1, Busy=0.
  - Start=1 and Abort=0: latch Steps to N, latch max(Half,1) to H, load S_in into S, clear Step_cnt, go RUN_PRESS.
- RUN_PRESS: Run=0 for H cycles, then RUN_REL.
- RUN_REL: Run=1 for H cycles. Then N==0 goes to DONE; otherwise go to CONT_PRESS.
- CONT_PRESS: Continue=0 for H cycles, then CONT_REL.
- CONT_REL: Continue=1 for H cycles. On the last cycle Step_cnt increments by 1 (mod 2^CNT_W).
  - Normal mode: new Step_cnt==N goes to DONE; otherwise go to CONT_PRESS.
  - Free-run mode (N all-ones): always returns to CONT_PRESS; Step_cnt wraps; exit only by Abort or Reset.
- DONE: Done=1 and Busy=0 for exactly one cycle, then IDLE. Run=1, Continue=1.
- Abort=1 in any non-IDLE state: next state IDLE, buttons released on the next edge, no Done pulse. S and Step_cnt keep their values.
- Start while not in IDLE is ignored; Steps, Half and S_in changes mid-sequence have no effect.
- Start and Abort high together in IDLE: Abort wins, stay IDLE.
- Start held high through DONE: a new sequence starts on the first IDLE cycle.
- Half-period counter: HALF_W bits, reloaded on every state entry; counts H cycles per level.

## Timing
- Reset values: state IDLE, Run=1, Continue=1, S=0, Busy=0, Done=0, Step_cnt=0, internal counters 0.
- Reset mid-sequence forces all of the above immediately (asynchronously). The sequence is lost.
- All outputs are registered, with no combinational path from inputs to outputs.
- Start latency: Start sampled at edge E. Run=0, Busy=1 and new S are visible after edge E; Run low for cycles E..E+H-1.
- Per Continue pulse: exactly H cycles low followed by H cycles high.
- Normal sequence length: 2H + 2H·N cycles Busy=1, then 1 Done cycle, then IDLE.
- Step_cnt updates on the same edge that leaves CONT_REL.
- Abort latency: one edge; Run=1 and Continue=1 after the edge that samples Abort=1.

## Test plan
- Reset released, inputs idle -> Run=1, Continue=1, S=0, Busy=0, Done=0, Step_cnt=0 held for 20 cycles.
- Start pulse with S_in=0x0014, Half=2, Steps=3 -> S=0x0014; Run low 2 cycles, high 2; then 3 Continue pulses of 2 low/2 high. Busy high 16 cycles, then Done for 1 cycle; Step_cnt=3.
- Half=0, Steps=0 -> Run low 1 cycle, high 1; Busy 2 cycles; Done; no Continue activity; Step_cnt=0.
- Steps=0xFFFF, Half=1 -> Continue toggles every cycle indefinitely, Step_cnt wraps 0xFFFF->0x0000. Abort mid-CONT_PRESS -> Continue=1 next cycle, IDLE, no Done.
- Start re-pulsed while Busy with different S_in and Steps -> ignored; S and sequence length unchanged.
- Reset asserted during CONT_PRESS -> Continue=1, Busy=0, S=0 immediately, before the next clock edge.
